// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the frame-buffer painter and its scanner.
//   draw_mode_t : draw command selector (FILL, CHECKER, RECT)
//   state_t     : painter FSM states
//   addr_width  : frame-buffer address width for an H x V frame; the
//                 frame buffer and display modules size their ports with it too
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CHECKER = 2'd1,
        RECT    = 2'd2
    } draw_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int addr_width(input int h, input int v);
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/frame_buffer_scan.sv
// Region scanner: walks a rectangular region of the frame row-major, one
// position per advance, tracking x, y and the linear pixel address.
//   clk, rst            : clock, synchronous active-high reset
//   load                : capture region bounds and start position
//   advance             : step to the next position in the region
//   x_start/x_end       : first/last column of the region
//   y_start/y_end       : first/last row of the region
//   addr_start          : linear address of (x_start, y_start), one spare MSB
//   x, y, addr          : current position
//   last                : current position is the final pixel of the region
module frame_buffer_scan
    import frame_buffer_pkg::*;
#(
    parameter int HOR = 640,
    parameter int XW  = 10,
    parameter int YW  = 9,
    parameter int AW  = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [XW-1:0] x_start,
    input  logic [XW-1:0] x_end,
    input  logic [YW-1:0] y_start,
    input  logic [YW-1:0] y_end,
    input  logic [AW:0]   addr_start,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [XW-1:0] x_first_q;
    logic [XW-1:0] x_last_q;
    logic [YW-1:0] y_last_q;
    logic [AW:0]   row_step_q;
    logic [AW:0]   addr_q;

    // NOTE: region bounds carry no reset; they are only read after a load
    // has written them, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (load) begin
            x_first_q  <= x_start;
            x_last_q   <= x_end;
            y_last_q   <= y_end;
            // Jump from the end of one row to the start of the next.
            row_step_q <= (AW+1)'(HOR) - (AW+1)'(x_end - x_start);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            addr_q <= '0;
        end else if (load) begin
            x      <= x_start;
            y      <= y_start;
            addr_q <= addr_start;
        end else if (advance) begin
            if (x == x_last_q) begin
                x      <= x_first_q;
                y      <= y + YW'(1);
                addr_q <= addr_q + row_step_q;
            end else begin
                x      <= x + XW'(1);
                addr_q <= addr_q + (AW+1)'(1);
            end
        end
    end

    assign addr = addr_q[AW-1:0];
    assign last = (x == x_last_q) && (y == y_last_q);

endmodule

// File: rtl/frame_buffer_painter.sv
// Frame-buffer painter: on a start command paints FILL, CHECKER or a clipped
// filled RECT into a single-port frame buffer, one pixel per ce cycle.
//   clk, rst, ce        : clock, synchronous active-high reset, clock enable
//   start               : draw request, accepted in IDLE when ce=1
//   mode, fg, bg, invert: draw operands, sampled on accept
//   rect_x/y/w/h        : RECT origin and size, sampled on accept
//   busy, done          : handshake; done pulses one cycle after the draw
//   wr_en/wr_addr/wr_data : frame buffer write port (registered)
module frame_buffer_painter
    import frame_buffer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int PIXEL_WIDTH       = 1,
    parameter int CHECKER_LOG2      = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         ce,
    input  logic                                         start,
    input  draw_mode_t                                   mode,
    input  logic [PIXEL_WIDTH-1:0]                       fg,
    input  logic [PIXEL_WIDTH-1:0]                       bg,
    input  logic                                         invert,
    input  logic [$clog2(HOR_ACTIVE_PIXELS)-1:0]         rect_x,
    input  logic [$clog2(VER_ACTIVE_PIXELS)-1:0]         rect_y,
    input  logic [$clog2(HOR_ACTIVE_PIXELS):0]           rect_w,
    input  logic [$clog2(VER_ACTIVE_PIXELS):0]           rect_h,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         wr_en,
    output logic [addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)-1:0] wr_addr,
    output logic [PIXEL_WIDTH-1:0]                       wr_data
);

    localparam int XW = $clog2(HOR_ACTIVE_PIXELS);
    localparam int YW = $clog2(VER_ACTIVE_PIXELS);
    localparam int AW = addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    // Two spare bits: rect_x + rect_w can reach nearly 3*2**XW.
    localparam int XC = XW + 2;
    localparam int YC = YW + 2;

    state_t                 state, state_next;
    logic                   busy_next, done_next, wr_en_next;
    logic [AW-1:0]          wr_addr_next;
    logic [PIXEL_WIDTH-1:0] wr_data_next;
    logic                   accept, load, advance;

    draw_mode_t             mode_q;
    logic [PIXEL_WIDTH-1:0] fg_q, bg_q;
    logic                   invert_q;

    // Clipped region, computed from the live inputs at accept time.
    logic [XC-1:0] x_sum, x_lim;
    logic [YC-1:0] y_sum, y_lim;
    logic          rect_empty, region_empty;
    logic [XW-1:0] x_start, x_end;
    logic [YW-1:0] y_start, y_end;
    logic [AW:0]   addr_start;

    assign x_sum = XC'(rect_x) + XC'(rect_w);
    assign y_sum = YC'(rect_y) + YC'(rect_h);
    assign x_lim = (x_sum > XC'(HOR_ACTIVE_PIXELS)) ? XC'(HOR_ACTIVE_PIXELS) : x_sum;
    assign y_lim = (y_sum > YC'(VER_ACTIVE_PIXELS)) ? YC'(VER_ACTIVE_PIXELS) : y_sum;
    assign rect_empty = (rect_w == '0) || (rect_h == '0)
                     || (XC'(rect_x) >= XC'(HOR_ACTIVE_PIXELS))
                     || (YC'(rect_y) >= YC'(VER_ACTIVE_PIXELS));

    always_comb begin
        if (mode == RECT) begin
            x_start      = rect_x;
            y_start      = rect_y;
            x_end        = XW'(x_lim - XC'(1));
            y_end        = YW'(y_lim - YC'(1));
            region_empty = rect_empty;
        end else begin
            x_start      = '0;
            y_start      = '0;
            x_end        = XW'(HOR_ACTIVE_PIXELS - 1);
            y_end        = YW'(VER_ACTIVE_PIXELS - 1);
            region_empty = 1'b0;
        end
    end

    // The only multiply; used once per accepted command.
    assign addr_start = (AW+1)'(y_start) * (AW+1)'(HOR_ACTIVE_PIXELS) + (AW+1)'(x_start);

    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic [AW-1:0] scan_addr;
    logic          scan_last;

    frame_buffer_scan #(
        .HOR (HOR_ACTIVE_PIXELS),
        .XW  (XW),
        .YW  (YW),
        .AW  (AW)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .x_start    (x_start),
        .x_end      (x_end),
        .y_start    (y_start),
        .y_end      (y_end),
        .addr_start (addr_start),
        .x          (scan_x),
        .y          (scan_y),
        .addr       (scan_addr),
        .last       (scan_last)
    );

    // Checker cell parity: bit 0 of the cell coordinates.
    logic [XW-1:0]          cell_x;
    logic [YW-1:0]          cell_y;
    logic [PIXEL_WIDTH-1:0] pixel;

    assign cell_x = scan_x >> CHECKER_LOG2;
    assign cell_y = scan_y >> CHECKER_LOG2;

    always_comb begin
        pixel = fg_q;
        if (mode_q == CHECKER) begin
            pixel = (cell_x[0] ^ cell_y[0] ^ invert_q) ? fg_q : bg_q;
        end
    end

    assign accept = ce && (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q   <= mode;
            fg_q     <= fg;
            bg_q     <= bg;
            invert_q <= invert;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        busy_next    = busy;
        done_next    = done;
        wr_en_next   = wr_en;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;
        load         = 1'b0;
        advance      = 1'b0;
        if (ce) begin
            done_next  = 1'b0;
            wr_en_next = 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy_next  = 1'b1;
                        load       = !region_empty;
                        state_next = region_empty ? FINISH : DRAW;
                    end
                end
                DRAW: begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = scan_addr;
                    wr_data_next = pixel;
                    advance      = 1'b1;
                    if (scan_last) begin
                        state_next = FINISH;
                    end
                end
                FINISH: begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_next;
            busy    <= busy_next;
            done    <= done_next;
            wr_en   <= wr_en_next;
            wr_addr <= wr_addr_next;
            wr_data <= wr_data_next;
        end
    end

endmodule
